// File: rtl/uart_pkg.sv
// Shared definitions for the io_uart peripheral: register map, bit indices, FSM states.
package uart_pkg;

  typedef enum logic [1:0] {
    UA_DATA   = 2'd0,
    UA_STATUS = 2'd1,
    UA_DIV    = 2'd2,
    UA_CTRL   = 2'd3
  } ua_e;

  localparam int ST_TXFULL  = 0;
  localparam int ST_TXEMPTY = 1;
  localparam int ST_RXV     = 2;
  localparam int ST_RXFULL  = 3;
  localparam int ST_OVR     = 4;
  localparam int ST_FERR    = 5;

  localparam int CTRL_RXIE = 0;
  localparam int CTRL_TXIE = 1;
  localparam int CTRL_LOOP = 2;

  localparam logic [15:0] DIV_MIN = 16'd4;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_st_e;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_st_e;

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO; a push on a full FIFO is accepted only when a pop happens in the same cycle.
module uart_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic [W-1:0]  din_i,
  input  logic          pop_i,
  output logic [W-1:0]  dout_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] cnt_q;
  logic          do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign count_o = cnt_q;
  assign dout_o  = mem_q[rptr_q];
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= din_i;
  end

endmodule

// File: rtl/io_uart.sv
// Memory-mapped 8N1 UART with TX/RX FIFOs, programmable divisor and level IRQ.
// Optional internal loopback (CTRL.LOOP) is built only when UART_LOOPBACK_EN is defined.
module io_uart
  import uart_pkg::*;
#(
  parameter int CLK_HZ   = 50_000_000,
  parameter int BAUD     = 115200,
  parameter int TX_DEPTH = 16,
  parameter int RX_DEPTH = 16
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic [1:0]  UART_A,
  input  logic        UART_WE,
  input  logic [31:0] UART_WD,
  input  logic        UART_RE,
  output logic [31:0] UART_RD,
  input  logic        RXD,
  output logic        TXD,
  output logic        IRQ
);

  localparam logic [15:0] DIV_RST = 16'(CLK_HZ / BAUD);
  localparam int TCW = $clog2(TX_DEPTH) + 1;
  localparam int RCW = $clog2(RX_DEPTH) + 1;

  logic [15:0] div_q;
  logic [2:0]  ctrl_q;
  logic        ovr_q, ferr_q, ovr_d, ferr_d, irq_q;

  logic wr_data, wr_stat, wr_div, wr_ctrl, rd_data;
  assign wr_data = UART_WE & (UART_A == UA_DATA);
  assign wr_stat = UART_WE & (UART_A == UA_STATUS);
  assign wr_div  = UART_WE & (UART_A == UA_DIV);
  assign wr_ctrl = UART_WE & (UART_A == UA_CTRL);
  assign rd_data = UART_RE & (UART_A == UA_DATA);

  logic           tx_pop, tx_full, tx_empty;
  logic [7:0]     tx_byte;
  logic [TCW-1:0] tx_cnt;
  logic           rx_push, rx_pop, rx_full, rx_empty;
  logic [7:0]     rx_byte;
  logic [RCW-1:0] rx_cnt;

  uart_fifo #(.W(8), .DEPTH(TX_DEPTH)) u_txf (
    .clk(CLK), .rst_n(RESET_N), .push_i(wr_data), .din_i(UART_WD[7:0]), .pop_i(tx_pop),
    .dout_o(tx_byte), .full_o(tx_full), .empty_o(tx_empty), .count_o(tx_cnt)
  );

  // ---------------- TX ----------------
  tx_st_e      tx_st_q;
  logic [15:0] tx_div_q, tx_c_q;
  logic [7:0]  tx_sh_q;
  logic [2:0]  tx_bit_q;
  logic        txd_q, tx_end, tx_idle;

  assign tx_end  = (tx_c_q == tx_div_q - 16'd1);
  assign tx_idle = (tx_st_q == TX_IDLE);
  assign tx_pop  = ~tx_empty & (tx_idle | ((tx_st_q == TX_STOP) & tx_end));

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      tx_st_q  <= TX_IDLE;
      tx_div_q <= DIV_RST;
      tx_c_q   <= '0;
      tx_sh_q  <= '0;
      tx_bit_q <= '0;
      txd_q    <= 1'b1;
    end else begin
      tx_c_q <= tx_end ? 16'd0 : tx_c_q + 16'd1;
      if (tx_pop) begin
        // Frame start: latch divisor so mid-frame DIV writes only affect the next frame.
        tx_st_q  <= TX_START;
        tx_div_q <= div_q;
        tx_sh_q  <= tx_byte;
        tx_c_q   <= '0;
        txd_q    <= 1'b0;
      end else begin
        case (tx_st_q)
          TX_IDLE: tx_c_q <= '0;
          TX_START: if (tx_end) begin
            tx_st_q  <= TX_DATA;
            tx_bit_q <= '0;
            txd_q    <= tx_sh_q[0];
            tx_sh_q  <= {1'b0, tx_sh_q[7:1]};
          end
          TX_DATA: if (tx_end) begin
            if (tx_bit_q == 3'd7) begin
              tx_st_q <= TX_STOP;
              txd_q   <= 1'b1;
            end else begin
              tx_bit_q <= tx_bit_q + 3'd1;
              txd_q    <= tx_sh_q[0];
              tx_sh_q  <= {1'b0, tx_sh_q[7:1]};
            end
          end
          TX_STOP: if (tx_end) tx_st_q <= TX_IDLE;
          default: tx_st_q <= TX_IDLE;
        endcase
      end
    end
  end

  assign TXD = txd_q;

  // ---------------- RX ----------------
  logic rx_in, rx_s1_q, rx_s2_q, rx_prev_q;
`ifdef UART_LOOPBACK_EN
  assign rx_in = ctrl_q[CTRL_LOOP] ? txd_q : RXD;
`else
  assign rx_in = RXD;
`endif

  rx_st_e      rx_st_q;
  logic [15:0] rx_div_q, rx_c_q;
  logic [7:0]  rx_sh_q;
  logic [2:0]  rx_bit_q;
  logic        rx_end, rx_half, rx_stop_smp, ovr_set, ferr_set;

  assign rx_end      = (rx_c_q == rx_div_q - 16'd1);
  assign rx_half     = (rx_c_q == (rx_div_q >> 1) - 16'd1);
  assign rx_stop_smp = (rx_st_q == RX_STOP) & rx_end;
  assign rx_push     = rx_stop_smp & rx_s2_q;
  assign ferr_set    = rx_stop_smp & ~rx_s2_q;
  assign rx_pop      = rd_data & ~rx_empty;
  assign ovr_set     = rx_push & rx_full & ~rx_pop;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
      rx_st_q   <= RX_IDLE;
      rx_div_q  <= DIV_RST;
      rx_c_q    <= '0;
      rx_sh_q   <= '0;
      rx_bit_q  <= '0;
    end else begin
      rx_s1_q   <= rx_in;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
      rx_c_q    <= rx_c_q + 16'd1;
      case (rx_st_q)
        RX_IDLE: if (rx_prev_q & ~rx_s2_q) begin
          rx_st_q  <= RX_START;
          rx_div_q <= div_q;
          rx_c_q   <= '0;
        end
        RX_START: if (rx_half) begin
          rx_st_q  <= rx_s2_q ? RX_IDLE : RX_DATA;
          rx_c_q   <= '0;
          rx_bit_q <= '0;
        end
        RX_DATA: if (rx_end) begin
          rx_c_q  <= '0;
          rx_sh_q <= {rx_s2_q, rx_sh_q[7:1]};
          if (rx_bit_q == 3'd7) rx_st_q <= RX_STOP;
          else rx_bit_q <= rx_bit_q + 3'd1;
        end
        RX_STOP: if (rx_end) rx_st_q <= rx_s2_q ? RX_IDLE : RX_WAIT;
        RX_WAIT: if (rx_s2_q) rx_st_q <= RX_IDLE;
        default: rx_st_q <= RX_IDLE;
      endcase
    end
  end

  uart_fifo #(.W(8), .DEPTH(RX_DEPTH)) u_rxf (
    .clk(CLK), .rst_n(RESET_N), .push_i(rx_push), .din_i(rx_sh_q), .pop_i(rx_pop),
    .dout_o(rx_byte), .full_o(rx_full), .empty_o(rx_empty), .count_o(rx_cnt)
  );

  // ---------------- registers ----------------
  logic txempty, rxv;
  assign txempty = tx_empty & tx_idle;
  assign rxv     = ~rx_empty;

  // Hardware set wins over a same-cycle W1C clear.
  assign ovr_d  = (ovr_q  & ~(wr_stat & UART_WD[ST_OVR]))  | ovr_set;
  assign ferr_d = (ferr_q & ~(wr_stat & UART_WD[ST_FERR])) | ferr_set;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      div_q  <= DIV_RST;
      ctrl_q <= '0;
      ovr_q  <= 1'b0;
      ferr_q <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      ovr_q  <= ovr_d;
      ferr_q <= ferr_d;
      irq_q  <= (ctrl_q[CTRL_RXIE] & rxv) | (ctrl_q[CTRL_TXIE] & txempty);
      if (wr_div) div_q <= (UART_WD[15:0] < DIV_MIN) ? DIV_MIN : UART_WD[15:0];
`ifdef UART_LOOPBACK_EN
      if (wr_ctrl) ctrl_q <= UART_WD[2:0];
`else
      if (wr_ctrl) ctrl_q <= {1'b0, UART_WD[1:0]};
`endif
    end
  end

  assign IRQ = irq_q;

  always_comb begin
    UART_RD = '0;
    case (UART_A)
      UA_DATA:   UART_RD = rxv ? {23'b0, 1'b1, rx_byte} : 32'd0;
      UA_STATUS: UART_RD = {16'b0, 8'(rx_cnt), 2'b0, ferr_q, ovr_q, rx_full, rxv, txempty, tx_full};
      UA_DIV:    UART_RD = {16'b0, div_q};
      UA_CTRL:   UART_RD = {29'b0, ctrl_q};
      default:   UART_RD = '0;
    endcase
  end

  logic unused_ok;
  assign unused_ok = ^{UART_WD[31:16], tx_cnt};

endmodule

// File: tb/tb_io_uart.sv
// Directed self-checking bench for io_uart (DIV=8 for serial tests).
module tb_io_uart;
  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic [1:0]  UART_A = 2'd0;
  logic        UART_WE = 1'b0;
  logic [31:0] UART_WD = '0;
  logic        UART_RE = 1'b0;
  logic [31:0] UART_RD;
  logic        RXD = 1'b1;
  logic        TXD;
  logic        IRQ;

  int checks = 0;
  int errors = 0;

  io_uart dut (
    .CLK(CLK), .RESET_N(RESET_N), .UART_A(UART_A), .UART_WE(UART_WE), .UART_WD(UART_WD),
    .UART_RE(UART_RE), .UART_RD(UART_RD), .RXD(RXD), .TXD(TXD), .IRQ(IRQ)
  );

  always #5 CLK = ~CLK;

  // All bus tasks start and end just after a falling edge.
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    UART_A = a; UART_WD = d; UART_WE = 1'b1;
    @(posedge CLK); @(negedge CLK);
    UART_WE = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    UART_A = a; #1 d = UART_RD;
  endtask

  task automatic pop(output logic [31:0] d);
    UART_A = 2'd0; UART_RE = 1'b1; #1 d = UART_RD;
    @(posedge CLK); @(negedge CLK);
    UART_RE = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input logic stopbit);
    logic [9:0] fr;
    fr = {stopbit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      RXD = fr[i];
      repeat (8) @(negedge CLK);
    end
    RXD = 1'b1;
    repeat (2) @(negedge CLK);
  endtask

  task automatic test_reset;
    logic [31:0] d;
    rd(2'd1, d); checks++; if (d !== 32'h2) begin errors++; $display("FAIL reset_status got %h exp %h", d, 32'h2); end
    rd(2'd2, d); checks++; if (d !== 32'd434) begin errors++; $display("FAIL reset_div got %h exp %h", d, 32'd434); end
    rd(2'd3, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_ctrl got %h exp 0", d); end
    rd(2'd0, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_data got %h exp 0", d); end
    checks++; if (TXD !== 1'b1) begin errors++; $display("FAIL reset_txd got %b exp 1", TXD); end
    checks++; if (IRQ !== 1'b0) begin errors++; $display("FAIL reset_irq got %b exp 0", IRQ); end
  endtask

  task automatic test_div;
    logic [31:0] d;
    wr(2'd2, 32'hFFFF_0002); rd(2'd2, d);
    checks++; if (d !== 32'd4) begin errors++; $display("FAIL div_min got %h exp 4", d); end
    wr(2'd2, 32'd8); rd(2'd2, d);
    checks++; if (d !== 32'd8) begin errors++; $display("FAIL div8 got %h exp 8", d); end
  endtask

  task automatic test_tx;
    logic [9:0]  fr;
    logic [31:0] d;
    fr = {1'b1, 8'h55, 1'b0};
    wr(2'd0, 32'h55);
    rd(2'd1, d);
    checks++; if (d[1] !== 1'b0) begin errors++; $display("FAIL tx_busy_txempty got %b exp 0", d[1]); end
    for (int k = 0; k < 10; k++) begin
      @(negedge CLK);
      checks++; if (TXD !== fr[k]) begin errors++; $display("FAIL tx_bit%0d_first got %b exp %b", k, TXD, fr[k]); end
      repeat (6) @(negedge CLK);
      checks++; if (TXD !== fr[k]) begin errors++; $display("FAIL tx_bit%0d_last got %b exp %b", k, TXD, fr[k]); end
      @(negedge CLK);
    end
    rd(2'd1, d);
    checks++; if (d[1] !== 1'b0) begin errors++; $display("FAIL tx_stop_txempty got %b exp 0", d[1]); end
    @(negedge CLK); rd(2'd1, d);
    checks++; if (d[1] !== 1'b1) begin errors++; $display("FAIL tx_done_txempty got %b exp 1", d[1]); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] d;
    wr(2'd0, 32'hFF);
    wr(2'd0, 32'h00);
    repeat (79) @(negedge CLK);
    checks++; if (TXD !== 1'b1) begin errors++; $display("FAIL b2b_stop got %b exp 1", TXD); end
    @(negedge CLK);
    checks++; if (TXD !== 1'b0) begin errors++; $display("FAIL b2b_start got %b exp 0", TXD); end
    rd(2'd1, d);
    checks++; if (d[1] !== 1'b0) begin errors++; $display("FAIL b2b_txempty got %b exp 0", d[1]); end
    repeat (85) @(negedge CLK); rd(2'd1, d);
    checks++; if (d !== 32'h2) begin errors++; $display("FAIL b2b_done got %h exp 2", d); end
  endtask

  task automatic test_rx;
    logic [31:0] d;
    send(8'hA3, 1'b1);
    rd(2'd1, d);
    checks++; if (d !== 32'h0106) begin errors++; $display("FAIL rx_status got %h exp %h", d, 32'h0106); end
    pop(d);
    checks++; if (d !== 32'h1A3) begin errors++; $display("FAIL rx_data got %h exp %h", d, 32'h1A3); end
    pop(d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL rx_empty_data got %h exp 0", d); end
  endtask

  task automatic test_overrun;
    logic [31:0] d;
    for (int i = 0; i < 17; i++) send(8'(8'h40 + i), 1'b1);
    rd(2'd1, d);
    checks++; if (d !== 32'h101E) begin errors++; $display("FAIL ovr_status got %h exp %h", d, 32'h101E); end
    wr(2'd1, 32'h10); rd(2'd1, d);
    checks++; if (d !== 32'h100E) begin errors++; $display("FAIL ovr_clear got %h exp %h", d, 32'h100E); end
    for (int i = 0; i < 16; i++) begin
      pop(d);
      checks++;
      if (d !== 32'(32'h140 + i)) begin errors++; $display("FAIL ovr_byte%0d got %h exp %h", i, d, 32'h140 + i); end
    end
    rd(2'd1, d);
    checks++; if (d !== 32'h2) begin errors++; $display("FAIL ovr_drained got %h exp 2", d); end
  endtask

  task automatic test_ferr_glitch;
    logic [31:0] d;
    send(8'h5A, 1'b0);
    repeat (10) @(negedge CLK); rd(2'd1, d);
    checks++; if (d !== 32'h22) begin errors++; $display("FAIL ferr_status got %h exp %h", d, 32'h22); end
    wr(2'd1, 32'h20); rd(2'd1, d);
    checks++; if (d !== 32'h2) begin errors++; $display("FAIL ferr_clear got %h exp 2", d); end
    RXD = 1'b0; @(negedge CLK); RXD = 1'b1;
    repeat (100) @(negedge CLK); rd(2'd1, d);
    checks++; if (d !== 32'h2) begin errors++; $display("FAIL glitch_status got %h exp 2", d); end
  endtask

  task automatic test_irq;
    logic [31:0] d;
    wr(2'd3, 32'h2); @(negedge CLK);
    checks++; if (IRQ !== 1'b1) begin errors++; $display("FAIL irq_tx got %b exp 1", IRQ); end
    wr(2'd3, 32'h1); @(negedge CLK);
    checks++; if (IRQ !== 1'b0) begin errors++; $display("FAIL irq_rx_idle got %b exp 0", IRQ); end
    send(8'h7E, 1'b1);
    checks++; if (IRQ !== 1'b1) begin errors++; $display("FAIL irq_rx got %b exp 1", IRQ); end
    pop(d); @(negedge CLK);
    checks++; if (IRQ !== 1'b0) begin errors++; $display("FAIL irq_rx_clear got %b exp 0", IRQ); end
    checks++; if (d !== 32'h17E) begin errors++; $display("FAIL irq_rx_data got %h exp %h", d, 32'h17E); end
  endtask

  task automatic test_loop;
    logic [31:0] d;
    wr(2'd3, 32'h5); rd(2'd3, d);
`ifdef UART_LOOPBACK_EN
    checks++; if (d !== 32'h5) begin errors++; $display("FAIL loop_ctrl got %h exp 5", d); end
    RXD = 1'b0;
    wr(2'd0, 32'h3C);
    checks++; if (IRQ !== 1'b0) begin errors++; $display("FAIL loop_irq_pre got %b exp 0", IRQ); end
    repeat (100) @(negedge CLK);
    checks++; if (IRQ !== 1'b1) begin errors++; $display("FAIL loop_irq got %b exp 1", IRQ); end
    pop(d);
    checks++; if (d !== 32'h13C) begin errors++; $display("FAIL loop_data got %h exp %h", d, 32'h13C); end
    RXD = 1'b1;
`else
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL loop_ctrl got %h exp 1", d); end
`endif
    wr(2'd3, 32'h0);
  endtask

  initial begin
    repeat (3) @(negedge CLK);
    test_reset;
    RESET_N = 1'b1;
    @(negedge CLK);
    test_reset;
    test_div;
    test_tx;
    test_back_to_back;
    test_rx;
    test_overrun;
    test_ferr_glitch;
    test_irq;
    test_loop;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
